// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state and port IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin picker: on conflict the port not granted last wins.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = PORT_I;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[PORT_D]) begin
      gnt_id = PORT_D;
    end
    gnt = '0;
    if (|req) begin
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports;
// each transaction: accept in IDLE, hold ACCESS_CYCLES on the port, one-cycle rvalid.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned MEM_WIDTH     = 32,
  parameter  int unsigned MEM_SIZE      = 256,
  parameter  int unsigned ACCESS_CYCLES = 1,
  localparam int unsigned ADDR_W        = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic                 i_ready,
  output logic                 i_rvalid,
  output logic [MEM_WIDTH-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [MEM_WIDTH-1:0] d_wdata,
  output logic                 d_ready,
  output logic                 d_rvalid,
  output logic [MEM_WIDTH-1:0] d_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MEM_WIDTH-1:0]   i_rdata_q, i_rdata_d;
  logic [MEM_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                   i_rvalid_q, i_rvalid_d;
  logic                   d_rvalid_q, d_rvalid_d;

  logic [1:0]             gnt;
  logic                   gnt_id;

  mem_arb_rr_pick u_pick (
    .req        ({d_req, i_req}),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          i_ready      = gnt[PORT_I];
          d_ready      = gnt[PORT_D];
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          we_d         = gnt[PORT_D] & d_we;
          addr_d       = gnt[PORT_D] ? d_addr : i_addr;
          wdata_d      = gnt[PORT_D] ? d_wdata : wdata_q;
          cnt_d        = CNT_W'(ACCESS_CYCLES - 1);
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == PORT_D) d_rdata_d = mem_read_val;
            else                   i_rdata_d = mem_read_val;
          end
          // rvalid is set on entry to DONE so it is a flop output for exactly that cycle
          d_rvalid_d = (owner_q == PORT_D);
          i_rvalid_d = (owner_q == PORT_I);
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_rvalid_q   <= i_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  // Enables decode straight from flops so an asynchronous reset drops them at once
  assign mem_read_en   = (state_q == ST_ACCESS) && !we_q;
  assign mem_write_en  = (state_q == ST_ACCESS) && we_q && (cnt_q == '0);
  assign mem_addr      = addr_q;
  assign mem_write_val = wdata_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign i_rvalid      = i_rvalid_q;
  assign d_rvalid      = d_rvalid_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance with 1 access cycle, one with 3,
// each backed by its own behavioural memory.
module tb_memory_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst1_n, rst3_n;
  logic          i_req1, d_req1, i_req3, d_req3;
  logic [AW-1:0] i_addr, d_addr;
  logic          d_we;
  logic [W-1:0]  d_wdata;

  logic          i1_ready, i1_rvalid, d1_ready, d1_rvalid, m1_re, m1_we, busy1;
  logic [W-1:0]  i1_rdata, d1_rdata, m1_wval, m1_rval;
  logic [AW-1:0] m1_addr;
  logic          i3_ready, i3_rvalid, d3_ready, d3_rvalid, m3_re, m3_we, busy3;
  logic [W-1:0]  i3_rdata, d3_rdata, m3_wval, m3_rval;
  logic [AW-1:0] m3_addr;

  logic [W-1:0]  mem1 [256];
  logic [W-1:0]  mem3 [256];
  int unsigned   wr3_cnt = 0;
  int unsigned   wr0;
  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.MEM_WIDTH(W), .MEM_SIZE(256), .ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .reset_n(rst1_n),
    .i_req(i_req1), .i_addr(i_addr), .i_ready(i1_ready), .i_rvalid(i1_rvalid), .i_rdata(i1_rdata),
    .d_req(d_req1), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d1_ready), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
    .mem_addr(m1_addr), .mem_read_en(m1_re), .mem_write_en(m1_we),
    .mem_write_val(m1_wval), .mem_read_val(m1_rval), .busy(busy1)
  );

  memory_arbiter #(.MEM_WIDTH(W), .MEM_SIZE(256), .ACCESS_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(rst3_n),
    .i_req(i_req3), .i_addr(i_addr), .i_ready(i3_ready), .i_rvalid(i3_rvalid), .i_rdata(i3_rdata),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d3_ready), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
    .mem_addr(m3_addr), .mem_read_en(m3_re), .mem_write_en(m3_we),
    .mem_write_val(m3_wval), .mem_read_val(m3_rval), .busy(busy3)
  );

  assign m1_rval = mem1[m1_addr];
  assign m3_rval = mem3[m3_addr];

  always @(posedge clk) begin
    if (m1_we) mem1[m1_addr] <= m1_wval;
    if (m3_we) begin
      mem3[m3_addr] <= m3_wval;
      wr3_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  initial begin
    i_req1 = 0; d_req1 = 0; i_req3 = 0; d_req3 = 0;
    i_addr = '0; d_addr = '0; d_we = 0; d_wdata = '0;
    rst1_n = 0; rst3_n = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    mem1[8'h10] = 32'hDEADBEEF;
    mem1[8'h08] = 32'h11111111;
    mem1[8'h09] = 32'h22222222;
    for (int k = 0; k < 4; k++) mem1[8'h40 + k] = 32'hA0000000 + k;
    mem3[8'h30] = 32'h00000055;

    // reset
    repeat (2) @(negedge clk);
    rst1_n = 1; rst3_n = 1;
    @(negedge clk); #1;
    check_eq("rst_i_ready",  i1_ready,  0);
    check_eq("rst_d_ready",  d1_ready,  0);
    check_eq("rst_i_rvalid", i1_rvalid, 0);
    check_eq("rst_d_rvalid", d1_rvalid, 0);
    check_eq("rst_re",       m1_re,     0);
    check_eq("rst_we",       m1_we,     0);
    check_eq("rst_addr",     m1_addr,   0);
    check_eq("rst_wval",     m1_wval,   0);
    check_eq("rst_i_rdata",  i1_rdata,  0);
    check_eq("rst_d_rdata",  d1_rdata,  0);
    check_eq("rst_busy",     busy1,     0);
    check_eq("rst_busy3",    busy3,     0);

    // single read, 1 access cycle
    @(negedge clk); i_req1 = 1; i_addr = 8'h10; #1;
    check_eq("rd_c0_i_ready", i1_ready, 1);
    check_eq("rd_c0_busy",    busy1,    0);
    check_eq("rd_c0_d_ready", d1_ready, 0);
    @(negedge clk); i_req1 = 0; #1;
    check_eq("rd_c1_i_ready", i1_ready, 0);
    check_eq("rd_c1_re",      m1_re,    1);
    check_eq("rd_c1_we",      m1_we,    0);
    check_eq("rd_c1_addr",    m1_addr,  8'h10);
    check_eq("rd_c1_busy",    busy1,    1);
    @(negedge clk); #1;
    check_eq("rd_c2_rvalid",  i1_rvalid, 1);
    check_eq("rd_c2_rdata",   i1_rdata,  32'hDEADBEEF);
    check_eq("rd_c2_re",      m1_re,     0);
    check_eq("rd_c2_d_rvalid", d1_rvalid, 0);
    @(negedge clk); #1;
    check_eq("rd_c3_rvalid",  i1_rvalid, 0);
    check_eq("rd_c3_busy",    busy1,     0);
    check_eq("rd_c3_hold",    i1_rdata,  32'hDEADBEEF);

    // conflict with both requests held from reset
    @(negedge clk);
    rst1_n = 0; i_req1 = 1; d_req1 = 1; i_addr = 8'h08; d_addr = 8'h09; d_we = 0;
    @(negedge clk); rst1_n = 1; #1;
    check_eq("cf_c0_d_ready", d1_ready, 1);
    check_eq("cf_c0_i_ready", i1_ready, 0);
    @(negedge clk); #1;
    check_eq("cf_c1_i_ready", i1_ready, 0);
    check_eq("cf_c1_d_ready", d1_ready, 0);
    check_eq("cf_c1_addr",    m1_addr,  8'h09);
    @(negedge clk); #1;
    check_eq("cf_c2_d_rvalid", d1_rvalid, 1);
    check_eq("cf_c2_d_rdata",  d1_rdata,  32'h22222222);
    check_eq("cf_c2_i_ready",  i1_ready,  0);
    @(negedge clk); #1;
    check_eq("cf_c3_i_ready", i1_ready, 1);
    check_eq("cf_c3_d_ready", d1_ready, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_eq("cf_c5_i_rvalid", i1_rvalid, 1);
    check_eq("cf_c5_i_rdata",  i1_rdata,  32'h11111111);
    @(negedge clk); #1;
    check_eq("cf_c6_d_ready", d1_ready, 1);
    check_eq("cf_c6_i_ready", i1_ready, 0);
    @(negedge clk); i_req1 = 0; d_req1 = 0;
    repeat (3) @(negedge clk);

    // back-to-back fetches
    i_req1 = 1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      i_addr = 8'h40 + 8'(k); #1;
      check_eq($sformatf("b2b_%0d_ready", k), i1_ready, 1);
      @(negedge clk); #1;
      check_eq($sformatf("b2b_%0d_gap", k), i1_ready, 0);
      @(negedge clk); #1;
      check_eq($sformatf("b2b_%0d_rvalid", k), i1_rvalid, 1);
      check_eq($sformatf("b2b_%0d_rdata", k), i1_rdata, 32'hA0000000 + k);
    end
    @(negedge clk); i_req1 = 0;

    // write then read, 3 access cycles
    @(negedge clk);
    d_req3 = 1; d_we = 1; d_addr = 8'h20; d_wdata = 32'h12345678; wr0 = wr3_cnt; #1;
    check_eq("wr_c0_d_ready", d3_ready, 1);
    @(negedge clk); d_req3 = 0; #1;
    check_eq("wr_c1_we",   m3_we, 0);
    check_eq("wr_c1_re",   m3_re, 0);
    check_eq("wr_c1_busy", busy3, 1);
    @(negedge clk); #1;
    check_eq("wr_c2_we",   m3_we, 0);
    @(negedge clk); #1;
    check_eq("wr_c3_we",   m3_we,   1);
    check_eq("wr_c3_addr", m3_addr, 8'h20);
    check_eq("wr_c3_wval", m3_wval, 32'h12345678);
    @(negedge clk); #1;
    check_eq("wr_c4_d_rvalid", d3_rvalid, 1);
    check_eq("wr_c4_we",       m3_we,     0);
    check_eq("wr_c4_d_rdata",  d3_rdata,  0);
    check_eq("wr_commit_once", wr3_cnt - wr0, 1);
    check_eq("wr_mem",         mem3[8'h20], 32'h12345678);
    @(negedge clk);
    d_req3 = 1; d_we = 0; d_addr = 8'h20; #1;
    check_eq("rb_c0_d_ready", d3_ready, 1);
    @(negedge clk); d_req3 = 0; #1;
    check_eq("rb_c1_re", m3_re, 1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_eq("rb_c3_re", m3_re, 1);
    check_eq("rb_c3_we", m3_we, 0);
    @(negedge clk); #1;
    check_eq("rb_c4_d_rvalid", d3_rvalid, 1);
    check_eq("rb_c4_d_rdata",  d3_rdata,  32'h12345678);

    // reset during ACCESS of a 3-cycle write
    @(negedge clk);
    d_req3 = 1; d_we = 1; d_addr = 8'h30; d_wdata = 32'h0000ABCD; wr0 = wr3_cnt; #1;
    check_eq("mr_c0_d_ready", d3_ready, 1);
    @(negedge clk); d_req3 = 0; #1;
    check_eq("mr_c1_busy", busy3, 1);
    @(negedge clk); rst3_n = 0; #1;
    check_eq("mr_rst_we",   m3_we, 0);
    check_eq("mr_rst_busy", busy3, 0);
    @(negedge clk); rst3_n = 1; #1;
    check_eq("mr_rst_addr", m3_addr, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check_eq($sformatf("mr_no_rvalid_%0d", c), d3_rvalid, 0);
    end
    check_eq("mr_no_write", wr3_cnt - wr0, 0);
    check_eq("mr_mem",      mem3[8'h30], 32'h00000055);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequencer and two-way arbiter sharing the single-port external memory behind `MemoryController` between the MIPS core's instruction-fetch port (read-only) and data port (read/write). Requests are accepted with a one-cycle ready pulse, arbitrated round-robin on conflict, and held on the memory port for a configurable number of wait-state cycles. Read data is returned registered with a one-cycle valid pulse. The block sits between the core and `MemoryController` and is the only driver of the memory port.

## Interface
- `MEM_WIDTH`, 32, data word width.
- `MEM_SIZE`, 256, words in memory; `ADDR_W = $clog2(MEM_SIZE)`.
- `ACCESS_CYCLES`, 1, cycles the memory port is held per access; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `i_req` in 1: fetch request; `i_addr` must be stable while high and not accepted.
- `i_addr` in ADDR_W: fetch word address.
- `i_ready` out 1: pulses 1 cycle when the fetch is accepted.
- `i_rvalid` out 1: pulses 1 cycle with fetch data.
- `i_rdata` out MEM_WIDTH: fetch data; holds its value between pulses.
- `d_req` in 1: data request; `d_we`, `d_addr` and `d_wdata` must be stable until accepted.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data word address.
- `d_wdata` in MEM_WIDTH: write data.
- `d_ready` out 1: pulses 1 cycle on acceptance.
- `d_rvalid` out 1: pulses 1 cycle on completion; also serves as the write acknowledge.
- `d_rdata` out MEM_WIDTH: read data; unchanged by writes.
- `mem_addr` out ADDR_W: to `MemoryController`.
- `mem_read_en` out 1: to `MemoryController`.
- `mem_write_en` out 1: to `MemoryController`.
- `mem_write_val` out MEM_WIDTH: to `MemoryController`.
- `mem_read_val` in MEM_WIDTH: from `MemoryController`; combinational from `mem_addr`.
- `busy` out 1: high in any state except IDLE.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE:**
  - If any request is present, grant one and assert its `*_ready` combinationally in the same cycle.
  - Latch owner, we, addr and wdata.
  - Load `cnt = ACCESS_CYCLES-1`, then go to ACCESS.
- **Arbitration:**
  - With a single request, that port wins.
  - With both requesting, the winner is the port not granted last (`last_grant` register).
  - `last_grant` resets to I, so D wins the first conflict.
- **ACCESS:**
  - `mem_addr` and `mem_write_val` are driven from the latched registers.
  - On reads, `mem_read_en = 1` for all ACCESS cycles.
  - On writes, `mem_write_en = 1` only in the final cycle (`cnt == 0`), so the write commits exactly once.
  - `cnt` decrements each cycle. When `cnt == 0`, capture `mem_read_val` into the owner's rdata register on reads, then go to DONE.
- **DONE:**
  - Owner's `*_rvalid = 1` for one cycle.
  - Enables are 0 and no request is accepted.
  - Go to IDLE.
- **Counter:** width `$clog2(ACCESS_CYCLES+1)`; never wraps, since it is reloaded on every accept.
- **Ready rule:** `*_ready` is never asserted outside IDLE. Requests arriving during ACCESS or DONE wait; they are not dropped.
- **Write/read overlap:** with `d_we = 1`, `mem_read_en` stays 0 throughout.

## Timing
- Accept occurs at cycle 0; ACCESS spans cycles 1..ACCESS_CYCLES; rvalid is asserted at cycle ACCESS_CYCLES+1.
- The next accept is possible at ACCESS_CYCLES+2, so throughput is 1 transaction per ACCESS_CYCLES+2 cycles.
- **Reset values:**
  - State IDLE, `busy = 0`.
  - All `*_ready`, `*_rvalid`, `mem_read_en`, `mem_write_en` = 0.
  - `mem_addr`, `mem_write_val`, `i_rdata`, `d_rdata` = 0.
  - `last_grant` = I.
- **Reset mid-operation:**
  - Enables drop immediately (asynchronous).
  - The in-flight transaction is discarded with no rvalid; a partial write never commits.
  - Requesters re-issue after reset.
- **Simultaneous requests:** both `i_req` and `d_req` in IDLE produce exactly one ready; the loser's ready follows no earlier than ACCESS_CYCLES+2 cycles later.
- Deassertion of `*_req` during ACCESS or DONE does not affect the granted transaction.

## Structure
- Shared package/header `mem_arb_pkg`:
  - State encoding (IDLE=0, ACCESS=1, DONE=2).
  - Port IDs (PORT_I=0, PORT_D=1).
- Sub-module `mem_arb_rr_pick`: combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: `gnt[1:0]` one-hot, `gnt_id`.
- Top holds FSM, counter, latched request registers and rdata registers; it instantiates `MemoryController` externally, not inside this block.

## Test plan
- **Reset:** with `ACCESS_CYCLES=1`, reset then release -> all outputs 0 and `busy = 0`.
- **Single read:** preload mem[0x10]=0xDEADBEEF; `i_req`, addr 0x10 -> `i_ready` at c0, `mem_read_en` at c1, `i_rvalid` at c2 with `i_rdata = 0xDEADBEEF`.
- **Write then read:** with `ACCESS_CYCLES=3`, D writes 0x12345678 to 0x20 -> `mem_write_en` high only at c3, `d_rvalid` at c4; a D read of 0x20 then returns 0x12345678.
- **Conflict:** `i_req` and `d_req` both held from reset -> D granted first, I granted at c3 (`ACCESS_CYCLES=1`); a third conflict is granted to D.
- **Reset mid-op:** `reset_n` low during ACCESS of a 3-cycle write -> `mem_write_en` never high, memory unchanged, no `d_rvalid`.
- **Back-to-back:** continuous `i_req` with incrementing addr -> one `i_ready` every ACCESS_CYCLES+2 cycles and in-order data.
